mdu_iterative: RTL and testbench

Iterative multiply/divide unit for the MIPS pipeline EX stage, executing MULT, MULTU, DIV and DIVU over multiple cycles and holding the architectural HI/LO registers. It is the upstream source of the pipeline registers' control: its `stall_o` is inverted onto the `ld_i` of the IF/ID and ID/EX pipeline registers, freezing them while an operation is in flight. It also supplies HI/LO to the MFHI/MFLO datapath.

---
 rtl/mdu_iterative.sv | 163 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, sign fix-up in a final cycle.
module mdu_iterative #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [1:0]            op_i,
   input  logic [DATA_WIDTH-1:0] rs_i,
   input  logic [DATA_WIDTH-1:0] rt_i,
   input  logic                  flush_i,
   input  logic                  mthi_i,
   input  logic                  mtlo_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  hilo_rd_i,
   output logic [DATA_WIDTH-1:0] hi_o,
   output logic [DATA_WIDTH-1:0] lo_o,
   output logic                  busy_o,
   output logic                  stall_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic            sgn_quo_q, sgn_quo_d;
   logic            sgn_rem_q, sgn_rem_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;

   logic            rs_neg, rt_neg;
   logic [W-1:0]    rs_mag, rt_mag;
   logic [W-1:0]    mul_addend;
   logic [W:0]      mul_sum;
   logic [W:0]      div_trial, div_diff;
   logic [2*W-1:0]  prod_fix;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (!flush_i && start_i) state_d = CALC;
         CALC: begin
            if (flush_i)              state_d = IDLE;
            else if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q != IDLE);
      stall_o = busy_o & (start_i | hilo_rd_i | mthi_i | mtlo_i);
   end

   // Operands are reduced to magnitudes at launch; only the result signs are remembered.
   always_comb begin
      rs_neg     = op_i[0] & rs_i[W-1];
      rt_neg     = op_i[0] & rt_i[W-1];
      rs_mag     = rs_neg ? -rs_i : rs_i;
      rt_mag     = rt_neg ? -rt_i : rt_i;
      mul_addend = acc_q[0] ? opa_q : '0;
      mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
      div_trial  = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff   = div_trial - {1'b0, opa_q};
      prod_fix   = sgn_quo_q ? -acc_q : acc_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      opa_d     = opa_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               // no writes
            end else if (start_i) begin
               cnt_d     = CNT_INIT;
               is_div_d  = op_i[1];
               sgn_quo_d = rs_neg ^ rt_neg;
               sgn_rem_d = rs_neg;
               if (op_i[1]) begin
                  opa_d = rt_mag;
                  acc_d = {{W{1'b0}}, rs_mag};
               end else begin
                  opa_d = rs_mag;
                  acc_d = {{W{1'b0}}, rt_mag};
               end
            end else begin
               if (mthi_i) hi_d = wdata_i;
               if (mtlo_i) lo_d = wdata_i;
            end
         end
         CALC: begin
            if (!flush_i) begin
               cnt_d = cnt_q - CW'(1);
               // Divide: remainder in the upper half, dividend shifts out while quotient shifts in.
               if (is_div_q) begin
                  if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                  else              acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b0};
               end else begin
                  acc_d = {mul_sum, acc_q[W-1:1]};
               end
            end
         end
         FIX: begin
            if (!flush_i) begin
               if (is_div_q) begin
                  hi_d = sgn_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                  lo_d = sgn_quo_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         opa_q     <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
         opa_q     <= opa_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed vectors, random ops against an arithmetic model, hazard/flush/reset sequences.
module tb_mdu_iterative;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, flush, mthi, mtlo, hilo_rd;
   logic [1:0]  op;
   logic [31:0] rs, rt, wdata;
   logic [31:0] hi, lo;
   logic        busy, stall;

   int tests = 0;
   int fails = 0;

   mdu_iterative #(.DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
      .rs_i(rs), .rt_i(rt), .flush_i(flush), .mthi_i(mthi), .mtlo_i(mtlo),
      .wdata_i(wdata), .hilo_rd_i(hilo_rd), .hi_o(hi), .lo_o(lo),
      .busy_o(busy), .stall_o(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] rs, rt, hi, lo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Architectural results from plain arithmetic (truncating signed division).
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (o)
         2'b00: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
         2'b01: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
            else begin eh = a % b; el = a / b; end
         end
         default: begin
            if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
            else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; end
         end
      endcase
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      op = o; rs = a; rt = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(lat);
   endtask

   initial begin
      vec_t vecs[6];
      int lat, sc, bc;
      logic [1:0]  ro;
      logic [31:0] ra, rb, eh, el;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFF9};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,        32'd14};
      vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      hilo_rd = 1'b0; op = 2'b00; rs = '0; rt = '0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat);
         check($sformatf("vec%0d_lat", i), lat, 33);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      end

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if (ro == 2'b11 && rb == 32'd0) rb = 32'd1;
         model(ro, ra, rb, eh, el);
         run_op(ro, ra, rb, lat);
         check($sformatf("rnd%0d_hi op%0d", i, ro), hi, eh);
         check($sformatf("rnd%0d_lo op%0d", i, ro), lo, el);
      end

      // MFHI/MFLO hazard raised partway through a DIVU
      @(negedge clk);
      op = 2'b10; rs = 32'hFFFF_0000; rt = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      sc = 0; bc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         hilo_rd = (c >= 5);
         #1;
         if (stall) sc++;
         if (busy) bc++;
      end
      hilo_rd = 1'b0;
      check("haz_stall_cycles", sc, 29);
      check("haz_busy_cycles", bc, 33);
      model(2'b10, 32'hFFFF_0000, 32'd3, eh, el);
      check("haz_hi", hi, eh);
      check("haz_lo", lo, el);

      // Back-to-back: second start held through the stall
      @(negedge clk);
      op = 2'b00; rs = 32'd3; rt = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 op = 2'b10; rs = 32'd1000; rt = 32'd9;
      wait_idle(lat);
      check("b2b_lat1", lat, 33);
      check("b2b_hi1", hi, 0);
      check("b2b_lo1", lo, 15);
      check("b2b_idle_stall", stall, 0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(lat);
      check("b2b_lat2", lat, 33);
      check("b2b_hi2", hi, 1);
      check("b2b_lo2", lo, 111);

      // Flush mid-CALC keeps prior HI/LO
      @(negedge clk); mthi = 1'b1; wdata = 32'hA;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'hB;
      @(negedge clk); mtlo = 1'b0;
      check("mt_hi", hi, 32'hA);
      check("mt_lo", lo, 32'hB);
      op = 2'b00; rs = 32'h1234; rt = 32'h5678; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", busy, 0);
      check("flush_hi", hi, 32'hA);
      check("flush_lo", lo, 32'hB);
      repeat (40) @(negedge clk);
      check("flush_hi_later", hi, 32'hA);
      check("flush_lo_later", lo, 32'hB);

      // MTHI/MTLO in the same cycle, then individually
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
      @(negedge clk); mtlo = 1'b0; wdata = 32'h55;
      check("mtboth_lo", lo, 32'h77);
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h66;
      check("mthi_55", hi, 32'h55);
      @(negedge clk); mtlo = 1'b0;
      check("mtlo_66", lo, 32'h66);
      check("mthi_kept", hi, 32'h55);

      // Asynchronous reset mid-CALC
      op = 2'b01; rs = 32'h0000_1111; rt = 32'h0000_2222; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_rel_busy", busy, 0);
      check("arst_rel_stall", stall, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
